mem_byte_initiator: RTL and testbench

MEM_BYTE_INITIATOR -- requirements
Module: mem_byte_initiator

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_byte_initiator.sv | 158 +++++++++++++++
 tb/tb_mem_byte_initiator.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serialising memory initiator.
// Holds the FSM state encoding, the word/byte geometry and a lane-select helper.
package mem_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_W         = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Extract byte lane 'idx' from a 32-bit word (lane 0 = bits 7:0).
   function automatic logic [BYTE_W-1:0] byte_lane(input logic [31:0] word,
                                                   input logic [1:0]  idx);
      return word[idx*BYTE_W +: BYTE_W];
   endfunction

endpackage

// File: rtl/mem_byte_initiator.sv
// mem_byte_initiator: turns one 32-bit CPU load/store into four byte accesses
// on a byte-wide memory, little-endian, then returns a single response.
// Optional build macro: MEM_BYTE_INITIATOR_ALIGN_CHECK_EN -- when defined,
// requests whose address is not word aligned are rejected without touching
// memory and answered immediately with resp_err_o=1.
//
// Handshakes: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; a response transfers on a rising edge where
// resp_valid_o and resp_ready_i are both high. While resp_valid_o is high the
// response payload does not change. req_ready_o is high only while idle, so
// no request is taken in the cycle a response completes.
module mem_byte_initiator
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_wr_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [31:0]       resp_rdata_o,
   output logic              resp_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   output logic              mem_wr_o,
   output logic              mem_rd_o,
   input  logic [7:0]        mem_rdata_i,
   output logic [1:0]        dbg_state_o
);

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic              accept;
   logic              capture;
   logic              reject;

`ifdef MEM_BYTE_INITIATOR_ALIGN_CHECK_EN
   // A request not on a word boundary is refused outright.
   assign reject = (req_addr_i[1:0] != 2'b00);
`else
   // Misaligned requests are simply carried out byte by byte.
   assign reject = 1'b0;
`endif

   // Next-state and output decode; everything defaults to the idle values.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      accept       = 1'b0;
      capture      = 1'b0;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_rdata_o = 32'h0;
      resp_err_o   = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = 8'h00;
      mem_wr_o     = 1'b0;
      mem_rd_o     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               accept  = 1'b1;
               idx_d   = 2'd0;
               state_d = reject ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // Address wraps naturally at 2^ADDR_W through the fixed-width add.
            mem_addr_o = addr_q + ADDR_W'(idx_q);
            if (wr_q) begin
               mem_wr_o    = 1'b1;
               mem_wdata_o = byte_lane(wdata_q, idx_q);
            end else begin
               mem_rd_o = 1'b1;
               capture  = 1'b1;
            end
            if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
               state_d = ST_RESP;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         ST_RESP: begin
            resp_valid_o = 1'b1;
            resp_rdata_o = rdata_q;
            resp_err_o   = err_q;
            if (resp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register and byte index; reset aborts any access in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Request capture: operation, base address and store data.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
      end else if (accept) begin
         wr_q    <= req_wr_i;
         addr_q  <= req_addr_i;
         wdata_q <= req_wdata_i;
      end
   end

   // Load assembly: each read byte lands in its little-endian lane.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= 32'h0;
      end else if (accept) begin
         rdata_q <= 32'h0;
      end else if (capture) begin
         rdata_q[idx_q*BYTE_W +: BYTE_W] <= mem_rdata_i;
      end
   end

`ifdef MEM_BYTE_INITIATOR_ALIGN_CHECK_EN
   // Error flag remembers whether the accepted request was refused.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= reject;
      end
   end
`else
   assign err_q = 1'b0;
`endif

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Bench for mem_byte_initiator: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level
// model (cycle count since acceptance + reference byte memory).
module tb_mem_byte_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_wr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   mem_byte_initiator #(.ADDR_W(32)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_wr_i     (req_wr),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .resp_rdata_o (resp_rdata),
      .resp_err_o   (resp_err),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_wr_o     (mem_wr),
      .mem_rd_o     (mem_rd),
      .mem_rdata_i  (mem_rdata),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- memories ----------------
   logic [7:0] env_mem [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] env_rd(input logic [31:0] a);
      if (env_mem.exists(a)) return env_mem[a];
      return dflt(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return dflt(a);
   endfunction

   assign mem_rdata = mem_rd ? env_rd(mem_addr) : 8'h00;

   always @(posedge clk) begin
      if (mem_wr) env_mem[mem_addr] = mem_wdata;
   end

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          chk_en   = 1'b0;
   bit          m_busy   = 1'b0;
   int          m_k      = 0;
   int          m_nbytes = 4;
   logic        m_wr     = 1'b0;
   logic        m_err    = 1'b0;
   logic [31:0] m_base   = 32'h0;
   logic [31:0] m_wdata  = 32'h0;
   logic [31:0] m_exp    = 32'h0;

   always @(posedge clk) begin : model
      logic [31:0] sh;
      // memory is not reset: a byte strobed in the reset cycle still lands
      if (m_busy && m_wr && m_k >= 1 && m_k <= m_nbytes) begin
         sh = m_wdata >> (8 * (m_k - 1));
         ref_mem[m_base + 32'(m_k - 1)] = sh[7:0];
      end
      if (rst) begin
         m_busy = 1'b0;
         chk_en = 1'b1;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy  = 1'b1;
            m_k     = 1;
            m_wr    = req_wr;
            m_base  = req_addr;
            m_wdata = req_wdata;
`ifdef MEM_BYTE_INITIATOR_ALIGN_CHECK_EN
            m_err = ((req_addr % 4) != 0);
`else
            m_err = 1'b0;
`endif
            m_nbytes = m_err ? 0 : 4;
            m_exp    = 32'h0;
            if (!req_wr && !m_err) begin
               for (int i = 0; i < 4; i++) begin
                  m_exp = m_exp | (32'(ref_rd(req_addr + 32'(i))) << (8 * i));
               end
            end
         end
      end else if (m_k > m_nbytes && resp_ready) begin
         m_busy = 1'b0;
      end else begin
         m_k++;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : compare
      bit          acc;
      bit          rsp;
      logic [31:0] sh;
      if (chk_en) begin
         acc = m_busy && m_k >= 1 && m_k <= m_nbytes;
         rsp = m_busy && m_k > m_nbytes;
         sh  = m_wdata >> (8 * (m_k - 1));
         chk("req_ready", 32'(req_ready), 32'(!m_busy));
         chk("mem_wr", 32'(mem_wr), 32'(acc && m_wr));
         chk("mem_rd", 32'(mem_rd), 32'(acc && !m_wr));
         chk("mem_addr", mem_addr, acc ? m_base + 32'(m_k - 1) : 32'h0);
         chk("mem_wdata", 32'(mem_wdata), (acc && m_wr) ? 32'(sh[7:0]) : 32'h0);
         chk("resp_valid", 32'(resp_valid), 32'(rsp));
         chk("resp_rdata", resp_rdata, (rsp && !m_wr) ? m_exp : 32'h0);
         chk("resp_err", 32'(resp_err), 32'(rsp && m_err));
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a falling edge; returns at the falling edge of cycle 1.
   task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d);
      int n;
      n         = 0;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Waits (bounded) for a response and consumes it.
   task automatic finish_resp();
      int n;
      n = 0;
      while (!resp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("resp_wait", 32'(resp_valid), 32'h1);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] word;
      logic [31:0] wa [4];

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Store 0xDEADBEEF at 0x10: bytes EF,BE,AD,DE at 0x10..0x13.
      word = 32'hDEADBEEF;
      send(1'b1, 32'h10, word);
      for (int i = 0; i < 4; i++) begin
         chk("st_wr", 32'(mem_wr), 32'h1);
         chk("st_addr", mem_addr, 32'h10 + 32'(i));
         chk("st_wdata", 32'(mem_wdata), 32'(word[8*i +: 8]));
         @(negedge clk);
      end
      chk("st_resp_valid", 32'(resp_valid), 32'h1);
      chk("st_resp_rdata", resp_rdata, 32'h0);
      finish_resp();
      chk("st_idle_ready", 32'(req_ready), 32'h1);

      // Load it back, then stall the response with a request pending.
      send(1'b0, 32'h10, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("ld_rd", 32'(mem_rd), 32'h1);
         chk("ld_addr", mem_addr, 32'h10 + 32'(i));
         @(negedge clk);
      end
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 32'h40;
      req_wdata = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", 32'(resp_valid), 32'h1);
         chk("stall_rdata", resp_rdata, 32'hDEADBEEF);
         chk("stall_ready", 32'(req_ready), 32'h0);
         chk("stall_strobe", 32'(mem_wr | mem_rd), 32'h0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      // request was still valid during the completing edge: must not be taken
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      chk("post_resp_ready", 32'(req_ready), 32'h1);
      chk("post_resp_valid", 32'(resp_valid), 32'h0);
      @(negedge clk);

      // Load straddling the top of the address space.
      send(1'b0, 32'hFFFFFFFE, 32'h0);
`ifdef MEM_BYTE_INITIATOR_ALIGN_CHECK_EN
      chk("mis_valid", 32'(resp_valid), 32'h1);
      chk("mis_err", 32'(resp_err), 32'h1);
      chk("mis_rdata", resp_rdata, 32'h0);
      chk("mis_strobe", 32'(mem_wr | mem_rd), 32'h0);
`else
      wa[0] = 32'hFFFFFFFE;
      wa[1] = 32'hFFFFFFFF;
      wa[2] = 32'h00000000;
      wa[3] = 32'h00000001;
      for (int i = 0; i < 4; i++) begin
         chk("wrap_rd", 32'(mem_rd), 32'h1);
         chk("wrap_addr", mem_addr, wa[i]);
         @(negedge clk);
      end
      chk("wrap_valid", 32'(resp_valid), 32'h1);
      chk("wrap_err", 32'(resp_err), 32'h0);
      chk("wrap_rdata", resp_rdata, 32'hA4A5A5A4);
`endif
      finish_resp();

      // Reset during cycle 2 of a store: only bytes 0 and 1 reach memory.
      send(1'b1, 32'h10, 32'h11223344);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_ready", 32'(req_ready), 32'h1);
      chk("rst_mid_valid", 32'(resp_valid), 32'h0);
      chk("rst_mid_err", 32'(resp_err), 32'h0);
      chk("rst_mid_rdata", resp_rdata, 32'h0);
      chk("rst_mid_addr", mem_addr, 32'h0);
      chk("rst_mid_wdata", 32'(mem_wdata), 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("rst_mid_strobe", 32'(mem_wr | mem_rd), 32'h0);
         @(negedge clk);
      end
      send(1'b0, 32'h10, 32'h0);
      repeat (4) @(negedge clk);
      chk("rst_mid_load", resp_rdata, 32'hDEAD3344);
      finish_resp();

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 2000; c++) begin
         rst       = ($urandom_range(0, 249) == 0);
         req_valid = $urandom_range(0, 1);
         req_wr    = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) req_addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
         else req_addr = 32'h100 + 32'($urandom_range(0, 15));
         req_wdata  = $urandom;
         resp_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
      end
      rst        = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
